// File: rtl/int_sequencer_pkg.sv
// Shared types and defaults for the interrupt sequencer: FSM encoding, address width,
// vector defaults and the vector-address helper.
package int_sequencer_pkg;

  localparam int AW = 16;
  localparam logic [AW-1:0] VEC_BASE_DEF   = 16'h0010;
  localparam logic [AW-1:0] VEC_STRIDE_DEF = 16'd4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2,
    ST_EXIT    = 2'd3
  } state_t;

  // Handler address for source idx; wraps modulo 2^AW.
  function automatic logic [AW-1:0] vec_addr(input logic [AW-1:0] base,
                                             input logic [AW-1:0] stride,
                                             input logic [2:0]    idx);
    return base + stride * {{(AW-3){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/int_sequencer_if.sv
// Bundle between the sequencer and its neighbours (IO pins, decoder, register file, PC logic).
// master = surrounding logic driving requests/strobes, slave = the sequencer itself.
interface int_sequencer_if #(parameter int NSRC = 4);
  logic [NSRC-1:0] irq;
  logic            ie_set;
  logic            ie_clr;
  logic            rti;
  logic            instr_done;
  logic [15:0]     next_pc;
  logic            istatus;
  logic            ienabled;
  logic [15:0]     intRA;
  logic            take_int;
  logic [15:0]     vector;
  logic [NSRC-1:0] ack;
  logic            ret;
  logic [NSRC-1:0] pending;

  modport master (
    output irq, ie_set, ie_clr, rti, instr_done, next_pc,
    input  istatus, ienabled, intRA, take_int, vector, ack, ret, pending
  );

  modport slave (
    input  irq, ie_set, ie_clr, rti, instr_done, next_pc,
    output istatus, ienabled, intRA, take_int, vector, ack, ret, pending
  );
endinterface

// File: rtl/int_sequencer_irq_edge_sync.sv
// One interrupt line: 2-flop synchroniser followed by an edge register.
// rise is high for one cycle, two clocks after the raw line goes high.
module irq_edge_sync (
  input  logic clk,
  input  logic clr,
  input  logic irq_async,
  output logic rise
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = irq_async;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;
endmodule

// File: rtl/int_sequencer.sv
// Interrupt controller/sequencer: latches and prioritises requests, enters a handler at
// instruction boundaries and drives the register file's interrupt bank controls.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int            NSRC       = 4,
  parameter logic [AW-1:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [AW-1:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input logic               clk,
  input logic               clr,
  int_sequencer_if.slave    bus
);

  logic [NSRC-1:0] irq_raw;
  logic [NSRC-1:0] irq_rise;

  assign irq_raw = bus.irq;

  irq_edge_sync u_sync [NSRC-1:0] (
    .clk       (clk),
    .clr       (clr),
    .irq_async (irq_raw),
    .rise      (irq_rise)
  );

  state_t          state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] ack_q, ack_d;
  logic            ienabled_q, ienabled_d;
  logic            istatus_q, istatus_d;
  logic            take_int_q, take_int_d;
  logic            ret_q, ret_d;
  logic [AW-1:0]   intra_q, intra_d;
  logic [AW-1:0]   vector_q, vector_d;
  logic [NSRC-1:0] win_oh;
  logic [2:0]      win_idx;

  always_comb begin
    // Isolate the lowest set bit: index 0 is the highest priority.
    win_oh  = pending_q & (~pending_q + NSRC'(1));
    win_idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (win_oh[i]) win_idx = 3'(i);
    end

    // A fresh edge outranks the acknowledge that would clear the same bit.
    pending_d  = (pending_q & ~ack_q) | irq_rise;
    ienabled_d = bus.ie_clr ? 1'b0 : (bus.ie_set ? 1'b1 : ienabled_q);
    intra_d    = intra_q;
    state_d    = state_q;
    take_int_d = 1'b0;
    ack_d      = '0;
    vector_d   = '0;
    ret_d      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.instr_done) begin
          intra_d = bus.next_pc;
          if (ienabled_q && (|pending_q)) begin
            state_d    = ST_ENTER;
            take_int_d = 1'b1;
            ack_d      = win_oh;
            vector_d   = vec_addr(VEC_BASE, VEC_STRIDE, win_idx);
          end
        end
      end
      ST_ENTER: state_d = ST_SERVICE;
      ST_SERVICE: begin
        if (bus.instr_done && bus.rti) begin
          state_d = ST_EXIT;
          ret_d   = 1'b1;
        end
      end
      ST_EXIT: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    istatus_d = (state_d == ST_SERVICE) || (state_d == ST_EXIT);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_RUN;
      pending_q  <= '0;
      ack_q      <= '0;
      ienabled_q <= 1'b0;
      istatus_q  <= 1'b0;
      take_int_q <= 1'b0;
      ret_q      <= 1'b0;
      intra_q    <= '0;
      vector_q   <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      ienabled_q <= ienabled_d;
      istatus_q  <= istatus_d;
      take_int_q <= take_int_d;
      ret_q      <= ret_d;
      intra_q    <= intra_d;
      vector_q   <= vector_d;
    end
  end

  assign bus.istatus  = istatus_q;
  assign bus.ienabled = ienabled_q;
  assign bus.intRA    = intra_q;
  assign bus.take_int = take_int_q;
  assign bus.vector   = vector_q;
  assign bus.ack      = ack_q;
  assign bus.ret      = ret_q;
  assign bus.pending  = pending_q;

endmodule
